// File: rtl/ram_lsu_arbiter.sv
// ram_lsu_arbiter
// Shares RAM read port 2 and the RAM write port between the core load/store
// stage and the debug/loader port. Byte-addressed RV32I loads and stores are
// turned into word-addressed RAM accesses with byte enables. Load data is
// lane-selected and sign/zero-extended after the RAM's one-cycle read latency.
// Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_size/     core request; size is the RV32I funct3
//   c_wdata
//   c_gnt                         one-cycle accept pulse to the core
//   c_rvalid/c_rdata/c_err        one-cycle response to the core
//   d_req/d_we/d_addr/d_wdata     debug request (word accesses only)
//   d_gnt/d_rvalid/d_rdata/d_err  debug accept and response
//   ram_addr, ram_rdata           RAM read port 2 (registered read data)
//   ram_w_enable/ram_w_addr/      RAM write port; the RAM writes whenever
//   ram_w_val/ram_byte_en         ram_byte_en is non-zero
module ram_lsu_arbiter #(
    parameter int RAM_WORDS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [2:0]  c_size,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [29:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic        ram_w_enable,
    output logic [29:0] ram_w_addr,
    output logic [31:0] ram_w_val,
    output logic [3:0]  ram_byte_en
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam logic [29:0] WORD_LIMIT = 30'(RAM_WORDS);

    logic [1:0]  state_q, state_d;
    logic        lastDbg_q, lastDbg_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        anyReq;
    logic        pickDbg;
    logic        grantNow;
    logic        selWe;
    logic [2:0]  selSize;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selErr;
    logic [31:0] laneData;
    logic [31:0] loadData;
    logic        storeNow;

    // Arbitration and request selection. When both sides ask, the one that
    // was not granted last wins; lastDbg_q resets high so the core wins the
    // first contested grant. The grant is gated by rst so every output is
    // quiet while reset is held, even if requests are already pending.
    always_comb begin
        anyReq   = c_req | d_req;
        pickDbg  = d_req & (~c_req | ~lastDbg_q);
        grantNow = (state_q == S_IDLE) & anyReq & ~rst;
        selWe    = pickDbg ? d_we    : c_we;
        selSize  = pickDbg ? SZ_W    : c_size;
        selAddr  = pickDbg ? d_addr  : c_addr;
        selWdata = pickDbg ? d_wdata : c_wdata;

        selErr = 1'b0;
        case (selSize)
            SZ_B, SZ_BU: selErr = 1'b0;
            SZ_H, SZ_HU: selErr = selAddr[0];
            SZ_W:        selErr = |selAddr[1:0];
            default:     selErr = 1'b1;
        endcase
        if (selAddr[31:2] >= WORD_LIMIT) begin
            selErr = 1'b1;
        end
    end

    // Load data path: shift the addressed lane down to bit 0, then extend.
    // Only legal, aligned sizes ever reach WAIT, so a word load has offset 0.
    always_comb begin
        laneData = ram_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_B:    loadData = {{24{laneData[7]}}, laneData[7:0]};
            SZ_H:    loadData = {{16{laneData[15]}}, laneData[15:0]};
            SZ_BU:   loadData = {24'b0, laneData[7:0]};
            SZ_HU:   loadData = {16'b0, laneData[15:0]};
            default: loadData = laneData;
        endcase
    end

    // Transaction sequencer: IDLE grants and latches, ACCESS drives the RAM,
    // WAIT captures the registered read data, RESP reports to the owner.
    // Errors skip straight to RESP so the RAM never sees an illegal access.
    always_comb begin
        state_d   = state_q;
        lastDbg_d = lastDbg_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (grantNow) begin
                    owner_d   = pickDbg;
                    lastDbg_d = pickDbg;
                    we_d      = selWe;
                    size_d    = selSize;
                    addr_d    = selAddr;
                    wdata_d   = selWdata;
                    rdata_d   = 32'b0;
                    err_d     = selErr;
                    state_d   = selErr ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT: begin
                rdata_d = loadData;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; an asynchronous reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lastDbg_q <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 3'b0;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            rdata_q   <= 32'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastDbg_q <= lastDbg_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // RAM port drive. The RAM writes on any non-zero byte enable, so the
    // enables are forced to zero everywhere except the ACCESS cycle of a store.
    always_comb begin
        storeNow     = (state_q == S_ACCESS) & we_q;
        ram_addr     = (state_q == S_ACCESS) ? addr_q[31:2] : 30'b0;
        ram_w_enable = storeNow;
        ram_w_addr   = storeNow ? addr_q[31:2] : 30'b0;
        ram_w_val    = 32'b0;
        ram_byte_en  = 4'b0;
        if (storeNow) begin
            case (size_q[1:0])
                2'b00: begin
                    ram_byte_en = 4'b0001 << addr_q[1:0];
                    ram_w_val   = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    ram_byte_en = 4'b0011 << addr_q[1:0];
                    ram_w_val   = {2{wdata_q[15:0]}};
                end
                default: begin
                    ram_byte_en = 4'b1111;
                    ram_w_val   = wdata_q;
                end
            endcase
        end
    end

    // Requester handshakes; only the owner of the transaction sees RESP.
    always_comb begin
        c_gnt    = grantNow & ~pickDbg;
        d_gnt    = grantNow & pickDbg;
        c_rvalid = (state_q == S_RESP) & ~owner_q;
        d_rvalid = (state_q == S_RESP) & owner_q;
        c_rdata  = c_rvalid ? rdata_q : 32'b0;
        d_rdata  = d_rvalid ? rdata_q : 32'b0;
        c_err    = c_rvalid & err_q;
        d_err    = d_rvalid & err_q;
    end

endmodule

// File: tb/tb_ram_lsu_arbiter.sv
// tb_ram_lsu_arbiter
// Self-checking bench for ram_lsu_arbiter. A behavioural RAM sits on the
// DUT's RAM ports; a separate byte-level reference memory predicts load data,
// store byte lanes and response timing. Expected responses are queued at
// grant time and popped by monitors whenever the DUT responds.
module tb_ram_lsu_arbiter;

    localparam int RAM_WORDS = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr;
    logic [2:0]  c_size;
    logic [31:0] c_wdata;
    logic        c_gnt, c_rvalid, c_err;
    logic [31:0] c_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [29:0] ram_addr, ram_w_addr;
    logic [31:0] ram_rdata, ram_w_val;
    logic        ram_w_enable;
    logic [3:0]  ram_byte_en;

    always #5 clk = ~clk;

    ram_lsu_arbiter #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_w_enable(ram_w_enable),
        .ram_w_addr(ram_w_addr), .ram_w_val(ram_w_val), .ram_byte_en(ram_byte_en)
    );

    logic [166:0] allOuts;
    assign allOuts = {c_gnt, c_rvalid, c_rdata, c_err, d_gnt, d_rvalid, d_rdata, d_err,
                      ram_addr, ram_w_enable, ram_w_addr, ram_w_val, ram_byte_en};

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  be;
        logic [31:0] val;
        logic [29:0] addr;
    } wr_t;

    resp_t coreQ[$];
    resp_t dbgQ[$];
    wr_t   wrQ[$];

    // Behavioural RAM: registered read, byte-lane writes on any enable.
    logic [31:0] mem [0:RAM_WORDS-1];
    logic        pokeEn = 1'b0;
    logic [29:0] pokeAddr = 30'b0;
    logic [31:0] pokeData = 32'b0;

    always @(posedge clk) begin
        if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end else if (ram_byte_en != 4'b0 && int'(ram_w_addr) < RAM_WORDS) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byte_en[i]) mem[ram_w_addr][8*i +: 8] <= ram_w_val[8*i +: 8];
            end
        end
        ram_rdata <= (int'(ram_addr) < RAM_WORDS) ? mem[ram_addr] : 32'hDEADBEEF;
    end

    // Reference memory and access rules.
    logic [31:0] refMem [0:RAM_WORDS-1];

    function automatic int sizeBytes(input logic [2:0] sz);
        case (sz[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic isErr(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b1;
        if ((a >> 2) >= 32'(RAM_WORDS)) return 1'b1;
        if (int'(a % 32'd4) % sizeBytes(sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] loadValue(input logic [2:0] sz, input logic [31:0] a);
        longint w, raw, full;
        int n, off;
        n    = sizeBytes(sz);
        off  = int'(a % 32'd4);
        w    = longint'(refMem[a / 32'd4]);
        full = longint'(1) << (8 * n);
        raw  = (w >> (8 * off)) % full;
        if (sz < 3'd4 && n < 4 && raw >= full / 2) raw = raw - full;
        return 32'(raw);
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one request, wait for its grant, and queue the predicted outcome.
    // With abortInAccess set, reset is pulsed in the ACCESS cycle instead.
    task automatic applyStimulus(input logic isDbg, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic useConst, input logic [31:0] constData,
                                 input logic abortInAccess);
        int waited;
        int n, off;
        logic got;
        logic [2:0] sz;
        resp_t r;
        wr_t w;
        sz = isDbg ? 3'd2 : size;
        if (isDbg) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            c_we = we; c_addr = addr; c_size = size; c_wdata = wdata; c_req = 1'b1;
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (isDbg ? d_gnt : c_gnt) got = 1'b1;
            else waited++;
        end
        checkOutput(isDbg ? "dbgGrant" : "coreGrant", 192'(got), 192'(1));
        if (got && !abortInAccess) begin
            r.data = 32'b0;
            r.err  = 1'b0;
            if (isErr(sz, addr)) begin
                r.err = 1'b1;
                r.cyc = cycle + 1;
            end else if (we) begin
                n   = sizeBytes(sz);
                off = int'(addr % 32'd4);
                r.cyc  = cycle + 2;
                w.cyc  = cycle + 1;
                w.addr = 30'(addr / 32'd4);
                w.be   = 4'b0;
                for (int i = 0; i < n; i++) begin
                    w.be[off + i] = 1'b1;
                    refMem[addr / 32'd4][8*(off + i) +: 8] = wdata[8*i +: 8];
                end
                for (int j = 0; j < 4; j++) w.val[8*j +: 8] = wdata[8*(j % n) +: 8];
                wrQ.push_back(w);
            end else begin
                r.data = useConst ? constData : loadValue(sz, addr);
                r.cyc  = cycle + 3;
            end
            if (isDbg) dbgQ.push_back(r);
            else coreQ.push_back(r);
        end
        @(posedge clk);
        #1;
        if (isDbg) d_req = 1'b0;
        else c_req = 1'b0;
        if (abortInAccess) begin
            rst = 1'b1;
            #1;
            checkOutput("resetInAccess", 192'(allOuts), 192'(0));
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic randomTraffic(input logic isDbg, input int count, input int maxGap);
        int pick, gap;
        logic [31:0] word, off, addr;
        logic [2:0] sz;
        for (int k = 0; k < count; k++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 7) word = 32'($urandom_range(0, 15));
            else if (pick < 9) word = 32'($urandom_range(490, 499));
            else word = 32'($urandom_range(500, 520));
            if (isDbg) off = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            else off = 32'($urandom_range(0, 3));
            addr = (word << 2) | off;
            pick = int'($urandom_range(0, 11));
            if (pick < 2) sz = 3'd0;
            else if (pick < 4) sz = 3'd1;
            else if (pick < 7) sz = 3'd2;
            else if (pick < 9) sz = 3'd4;
            else if (pick < 11) sz = 3'd5;
            else sz = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7));
            applyStimulus(isDbg, 1'($urandom_range(0, 1)), sz, addr, $urandom, 1'b0, 32'b0, 1'b0);
            gap = int'($urandom_range(0, maxGap));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Core response monitor.
    always @(negedge clk) begin : coreMon
        resp_t r;
        if (!rst) begin
            if (c_rvalid) begin
                if (coreQ.size() == 0) checkOutput("coreUnexpectedResp", 192'(c_rvalid), 192'(0));
                else begin
                    r = coreQ.pop_front();
                    checkOutput("coreResp", 192'({c_rdata, c_err, cycle}), 192'({r.data, r.err, r.cyc}));
                end
            end else begin
                checkOutput("coreQuiet", 192'({c_rdata, c_err}), 192'(0));
            end
        end
    end

    // Debug response monitor.
    always @(negedge clk) begin : dbgMon
        resp_t r;
        if (!rst) begin
            if (d_rvalid) begin
                if (dbgQ.size() == 0) checkOutput("dbgUnexpectedResp", 192'(d_rvalid), 192'(0));
                else begin
                    r = dbgQ.pop_front();
                    checkOutput("dbgResp", 192'({d_rdata, d_err, cycle}), 192'({r.data, r.err, r.cyc}));
                end
            end else begin
                checkOutput("dbgQuiet", 192'({d_rdata, d_err}), 192'(0));
            end
        end
    end

    // RAM write-port monitor: enables only in the predicted store cycle.
    always @(negedge clk) begin : wrMon
        wr_t w;
        if (!rst) begin
            if (wrQ.size() > 0 && wrQ[0].cyc == cycle) begin
                w = wrQ.pop_front();
                checkOutput("storeAccess",
                            192'({ram_w_enable, ram_byte_en, ram_w_val, ram_w_addr, ram_addr}),
                            192'({1'b1, w.be, w.val, w.addr, w.addr}));
            end else begin
                checkOutput("noWrite", 192'({ram_w_enable, ram_byte_en}), 192'(0));
            end
        end
    end

    // Arbitration monitor: single grant, only to a requester, alternating
    // under contention, core first after reset.
    logic lastDbg = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            lastDbg <= 1'b1;
        end else if (c_gnt || d_gnt) begin
            checkOutput("grantOneHot", 192'(c_gnt & d_gnt), 192'(0));
            if (c_req && d_req) checkOutput("roundRobin", 192'(d_gnt), 192'(!lastDbg));
            else checkOutput("grantToRequester", 192'({c_gnt & !c_req, d_gnt & !d_req}), 192'(0));
            lastDbg <= d_gnt;
        end
    end

    initial begin
        logic [31:0] v;
        int waited;
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h14; c_size = 3'd2; c_wdata = 32'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'b0;
        #1;
        checkOutput("resetOutputs", 192'(allOuts), 192'(0));
        c_req = 1'b0;
        d_req = 1'b0;

        for (int i = 0; i < RAM_WORDS; i++) begin
            v = (i == 5) ? 32'h8899AABB : $urandom;
            pokeEn = 1'b1; pokeAddr = 30'(i); pokeData = v; refMem[i] = v;
            @(posedge clk);
            #1;
        end
        pokeEn = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterReset", 192'(allOuts), 192'(0));
        @(posedge clk);
        #1;

        $display("[TB] directed loads and stores");
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h15, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd4, 32'h15, 32'h0, 1'b1, 32'h000000AA, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd1, 32'h16, 32'h0, 1'b1, 32'hFFFF8899, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h14, 32'h0, 1'b1, 32'h8899AABB, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h17, 32'h00000055, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h14, 32'h0, 1'b1, 32'h5599AABB, 1'b0);

        $display("[TB] directed errors");
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h22, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd1, 32'h15, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd3, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h7D0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h7CC, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("[TB] reset during store access");
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);

        $display("[TB] contention");
        fork
            randomTraffic(1'b0, 6, 0);
            randomTraffic(1'b1, 6, 0);
        join

        $display("[TB] random traffic");
        fork
            randomTraffic(1'b0, 150, 3);
            randomTraffic(1'b1, 150, 3);
        join

        waited = 0;
        while ((coreQ.size() != 0 || dbgQ.size() != 0 || wrQ.size() != 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checkOutput("drain", 192'({coreQ.size(), dbgQ.size(), wrQ.size()}), 192'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
